vector_router: RTL
==================

# vector_router

Parametrised multi-channel successor to the single-vector router. It reads a job of vectors from the on-chip activation/weight buffer (1-cycle read latency), packs each vector of runtime length `vecLen` into a `MaxWidth`-lane word, and distributes the vectors round-robin across `numCh` PE-row channels. Each channel has a valid/ready output handshake, so the block applies backpressure instead of assuming the PEs are always ready. It sits between the SRAM buffer and the matrix-multiply PE array.

## Interface
- `MaxWidth`, 9: lanes per output vector.
- `Depth`, 32: buffer depth; must be a power of two.
- `DataWidth`, 8: bits per element.
- `NumCh`, 4: physical output channels.
- `AddrWidth`, `$clog2(Depth)`: buffer address width.
- `LenWidth`, `$clog2(MaxWidth+1)`: width of `vecLen`.
- `ChWidth`, `$clog2(NumCh+1)`: width of `numCh`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `routeEn` in 1: job start; sampled only in IDLE.
- `startAddr`, `finalAddr` in AddrWidth: first vector start address; last permitted vector start address.
- `stride` in AddrWidth: address distance between consecutive vector starts.
- `vecLen` in LenWidth: elements per vector.
- `numCh` in ChWidth: active channels.
- `dataIn` in DataWidth: buffer read data, valid 1 cycle after `readEn`.
- `readEn` out 1, `readAddr` out AddrWidth: buffer read request.
- `dataOut` out NumCh*MaxWidth*DataWidth: channel c occupies bits [(c+1)*MaxWidth*DataWidth-1 : c*MaxWidth*DataWidth]; lane k of a channel occupies [(k+1)*DataWidth-1 -: DataWidth].
- `outValid` out NumCh, `outReady` in NumCh: per-channel handshake.
- `busy` out 1, `finished` out 1, `vecCount` out AddrWidth+1.

## Operation
- Config is latched on acceptance. `vecLen` is clamped to [1, MaxWidth]; 0 is treated as 1. `numCh` is clamped to [1, NumCh].
- States:
  - IDLE: if `routeEn`, latch config, clear `finished`/`vecCount`, set `busy`, go to FETCH.
  - FETCH: `readEn`=1, `readAddr` = vecBase + elemIdx, incremented every cycle. After issuing element vecLen-1, go to DRAIN.
  - DRAIN: `readEn`=0; capture the final element; go to DELIVER.
  - DELIVER: wait until the target channel is free (`outValid[c]`=0, or `outValid[c]`&&`outReady[c]` this cycle). Then load the pack register into channel c and set `outValid[c]`. Increment `vecCount`, advance c round-robin modulo numCh, and compute the next start = vecBase + stride. If that start exceeds `finalAddr`, overflows AddrWidth (carry out), or `stride`=0: set `finished`, clear `busy`, go to IDLE. Otherwise go to FETCH.
- Capture: the element issued in cycle n is written to lane elemIdx at the edge ending cycle n+1. Lanes at or above vecLen are zero in every loaded vector.
- Element addresses (vecBase + k) wrap modulo Depth.
- If `finalAddr` < `startAddr`, exactly one vector (at `startAddr`) is routed.
- Channel register: `dataOut`/`outValid[c]` hold stable until `outReady[c]`=1 at an edge, then `outValid[c]` clears. A simultaneous consume and load leaves `outValid[c]`=1 with the new data.
- `routeEn` outside IDLE is ignored. `finished` holds until the next accepted `routeEn`. Pending channel vectors stay valid after `finished`.
- Reset at any time: state IDLE and all outputs 0 (`readEn`, `readAddr`, `dataOut`, `outValid`, `busy`, `finished`, `vecCount`). The pack register is cleared and the channel pointer goes to 0.

## Timing
- `routeEn` is sampled at edge T. First read is in cycle T+1 (`readAddr`=`startAddr`); the last read is in cycle T+vecLen.
- DRAIN occupies cycle T+vecLen+1, DELIVER occupies T+vecLen+2, and `outValid[0]` is high from cycle T+vecLen+3.
- With no backpressure, the per-vector period is vecLen+2 cycles.
- Each DELIVER cycle spent waiting on a full channel adds one cycle.
- `finished` and `busy`=0 are visible the cycle after the last DELIVER.

## Test plan
- Buffer[i]=i, start=0, final=0, stride=9, vecLen=9, numCh=1, `outReady`=1 → one vector with lanes 0..8 = 00..08. `outValid[0]` rises 12 cycles after the `routeEn` edge; `finished`=1, `vecCount`=1.
- start=0, final=12, stride=4, vecLen=3, numCh=4 → 4 vectors at bases 0,4,8,12 on channels 0..3. Lanes 3..8 are zero; channel 2 holds 08,09,0A.
- Backpressure: as above with numCh=2 and `outReady[0]`=0 for 20 cycles → third vector stalls in DELIVER, `readEn` stays 0 during the stall, and no vector is lost or reordered.
- Wrap: start=30, vecLen=4, final=30 → reads addresses 30,31,0,1; with `stride`=0, one vector only.
- Clamp/edge: vecLen=0 → 1-element vectors. numCh=7 → clamped to 4. start=28, stride=8, final=31 → the overflow terminates the job after 1 vector.
- Reset mid-FETCH (drive `rst`=0 for one cycle) → all outputs 0 immediately. A later `routeEn` runs a clean job from channel 0.

Source files
------------

// File: rtl/vector_router.sv
// Multi-channel vector router: fetches vectors from a 1-cycle-latency buffer, packs them into
// MaxWidth-lane words and hands them round-robin to valid/ready output channels.
module vector_router #(
  parameter int unsigned MaxWidth  = 9,
  parameter int unsigned Depth     = 32,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned NumCh     = 4,
  parameter int unsigned AddrWidth = $clog2(Depth),
  parameter int unsigned LenWidth  = $clog2(MaxWidth + 1),
  parameter int unsigned ChWidth   = $clog2(NumCh + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                routeEn,
  input  logic [AddrWidth-1:0]                startAddr,
  input  logic [AddrWidth-1:0]                finalAddr,
  input  logic [AddrWidth-1:0]                stride,
  input  logic [LenWidth-1:0]                 vecLen,
  input  logic [ChWidth-1:0]                  numCh,
  input  logic [DataWidth-1:0]                dataIn,
  output logic                                readEn,
  output logic [AddrWidth-1:0]                readAddr,
  output logic [NumCh*MaxWidth*DataWidth-1:0] dataOut,
  output logic [NumCh-1:0]                    outValid,
  input  logic [NumCh-1:0]                    outReady,
  output logic                                busy,
  output logic                                finished,
  output logic [AddrWidth:0]                  vecCount
);

  localparam int unsigned VecBits = MaxWidth * DataWidth;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDeliver} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   base_q, base_d;
  logic [AddrWidth-1:0]   final_q, final_d;
  logic [AddrWidth-1:0]   stride_q, stride_d;
  logic [LenWidth-1:0]    len_q, len_d;
  logic [ChWidth-1:0]     nch_q, nch_d;
  logic [LenWidth-1:0]    idx_q, idx_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [LenWidth-1:0]    rd_idx_q, rd_idx_d;
  logic [VecBits-1:0]     pack_q, pack_d;
  logic [ChWidth-1:0]     ch_q, ch_d;
  logic                   busy_q, busy_d;
  logic                   fin_q, fin_d;
  logic [AddrWidth:0]     cnt_q, cnt_d;
  logic [VecBits-1:0]     data_q [NumCh];
  logic [VecBits-1:0]     data_d [NumCh];
  logic [NumCh-1:0]       valid_q, valid_d;
  logic [AddrWidth:0]     next_base;
  logic                   ch_free;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    final_d    = final_q;
    stride_d   = stride_q;
    len_d      = len_q;
    nch_d      = nch_q;
    idx_d      = idx_q;
    rd_valid_d = 1'b0;
    rd_idx_d   = idx_q;
    pack_d     = pack_q;
    ch_d       = ch_q;
    busy_d     = busy_q;
    fin_d      = fin_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    data_d     = data_q;
    ch_free    = 1'b0;
    next_base  = {1'b0, base_q} + {1'b0, stride_q};

    // Read data arrives one cycle after the request; write it into the lane it was fetched for.
    if (rd_valid_q) begin
      for (int k = 0; k < MaxWidth; k++) begin
        if (rd_idx_q == LenWidth'(k)) pack_d[k*DataWidth +: DataWidth] = dataIn;
      end
    end

    for (int c = 0; c < NumCh; c++) begin
      if (valid_q[c] && outReady[c]) valid_d[c] = 1'b0;
      if (ch_q == ChWidth'(c)) ch_free = !valid_q[c] || outReady[c];
    end

    unique case (state_q)
      StIdle: begin
        if (routeEn) begin
          base_d   = startAddr;
          final_d  = finalAddr;
          stride_d = stride;
          len_d    = (vecLen == '0) ? LenWidth'(1) :
                     (vecLen > LenWidth'(MaxWidth)) ? LenWidth'(MaxWidth) : vecLen;
          nch_d    = (numCh == '0) ? ChWidth'(1) :
                     (numCh > ChWidth'(NumCh)) ? ChWidth'(NumCh) : numCh;
          idx_d    = '0;
          ch_d     = '0;
          cnt_d    = '0;
          fin_d    = 1'b0;
          busy_d   = 1'b1;
          pack_d   = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        rd_valid_d = 1'b1;
        idx_d      = idx_q + LenWidth'(1);
        if (idx_q == len_q - LenWidth'(1)) begin
          idx_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: state_d = StDeliver;
      StDeliver: begin
        if (ch_free) begin
          for (int c = 0; c < NumCh; c++) begin
            if (ch_q == ChWidth'(c)) begin
              data_d[c]  = pack_q;
              valid_d[c] = 1'b1;
            end
          end
          cnt_d  = cnt_q + (AddrWidth + 1)'(1);
          ch_d   = (ch_q == nch_q - ChWidth'(1)) ? '0 : ch_q + ChWidth'(1);
          pack_d = '0;
          // Carry out of the address sum means the next vector would start past the buffer.
          if (next_base[AddrWidth] || (next_base[AddrWidth-1:0] > final_q) ||
              (stride_q == '0)) begin
            fin_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            base_d  = next_base[AddrWidth-1:0];
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      final_q    <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      nch_q      <= '0;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      pack_q     <= '0;
      ch_q       <= '0;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
      cnt_q      <= '0;
      valid_q    <= '0;
      for (int c = 0; c < NumCh; c++) data_q[c] <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      final_q    <= final_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      nch_q      <= nch_d;
      idx_q      <= idx_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
      pack_q     <= pack_d;
      ch_q       <= ch_d;
      busy_q     <= busy_d;
      fin_q      <= fin_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      for (int c = 0; c < NumCh; c++) data_q[c] <= data_d[c];
    end
  end

  always_comb begin
    readEn   = (state_q == StFetch);
    readAddr = readEn ? (base_q + AddrWidth'(idx_q)) : '0;
    dataOut  = '0;
    for (int c = 0; c < NumCh; c++) dataOut[c*VecBits +: VecBits] = data_q[c];
  end

  assign outValid = valid_q;
  assign busy     = busy_q;
  assign finished = fin_q;
  assign vecCount = cnt_q;

endmodule
